// File: rtl/gpu_pkg.sv
// Shared pipeline and LSU state encodings for the GPU core.
// Imported by the LSU and by the core scheduler.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_FETCH   = 3'd0,
        CORE_DECODE  = 3'd1,
        CORE_REQUEST = 3'd2,
        CORE_WAIT    = 3'd3,
        CORE_EXECUTE = 3'd4,
        CORE_UPDATE  = 3'd5,
        CORE_DONE    = 3'd6
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: turns one decoded LDR/STR into a single
// request on a memory-controller consumer port and returns load data.
import gpu_pkg::*;

module lsu #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    localparam int CNT_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_BITS-1:0] CNT_LAST = TIMEOUT_EN ? CNT_BITS'(TIMEOUT_CYCLES - 1) : {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(32'd1);

    lsu_state_t           state_r, state_s;
    logic                 op_write_r, op_write_s;
    logic [CNT_BITS-1:0]  cnt_r, cnt_s;
    logic                 read_valid_r, read_valid_s;
    logic                 write_valid_r, write_valid_s;
    logic [ADDR_BITS-1:0] read_addr_r, read_addr_s;
    logic [ADDR_BITS-1:0] write_addr_r, write_addr_s;
    logic [DATA_BITS-1:0] write_data_r, write_data_s;
    logic [DATA_BITS-1:0] out_r, out_s;
    logic                 error_r, error_s;
    logic                 grant_s;

    // Next-state and next-output logic; enable low overrides every state.
    always_comb begin
        state_s       = state_r;
        op_write_s    = op_write_r;
        cnt_s         = cnt_r;
        read_valid_s  = read_valid_r;
        write_valid_s = write_valid_r;
        read_addr_s   = read_addr_r;
        write_addr_s  = write_addr_r;
        write_data_s  = write_data_r;
        out_s         = out_r;
        error_s       = error_r;
        grant_s       = 1'b0;

        if (!enable) begin
            state_s       = LSU_IDLE;
            read_valid_s  = 1'b0;
            write_valid_s = 1'b0;
            error_s       = 1'b0;
        end else begin
            case (state_r)
                LSU_IDLE: begin
                    if (core_state == CORE_REQUEST) begin
                        if (decoded_mem_read_enable ^ decoded_mem_write_enable) begin
                            state_s    = LSU_REQUESTING;
                            op_write_s = decoded_mem_write_enable;
                            error_s    = 1'b0;
                        end else if (decoded_mem_read_enable && decoded_mem_write_enable) begin
                            state_s = LSU_DONE;
                            error_s = 1'b1;
                        end else begin
                            state_s = LSU_IDLE;
                        end
                    end else begin
                        state_s = LSU_IDLE;
                    end
                end
                LSU_REQUESTING: begin
                    cnt_s   = {CNT_BITS{1'b0}};
                    state_s = LSU_WAITING;
                    if (op_write_r) begin
                        write_valid_s = 1'b1;
                        write_addr_s  = ADDR_BITS'(rs);
                        write_data_s  = rt;
                    end else begin
                        read_valid_s = 1'b1;
                        read_addr_s  = ADDR_BITS'(rs);
                    end
                end
                LSU_WAITING: begin
                    // Only the ready of the recorded op counts; a grant beats a coincident timeout.
                    grant_s = op_write_r ? mem_write_ready : mem_read_ready;
                    if (grant_s) begin
                        state_s = LSU_DONE;
                        if (op_write_r) begin
                            write_valid_s = 1'b0;
                        end else begin
                            read_valid_s = 1'b0;
                            out_s        = mem_read_data;
                        end
                    end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
                        state_s       = LSU_DONE;
                        read_valid_s  = 1'b0;
                        write_valid_s = 1'b0;
                        error_s       = 1'b1;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state_s = LSU_IDLE;
                        error_s = 1'b0;
                    end else begin
                        state_s = LSU_DONE;
                    end
                end
                default: begin
                    state_s = LSU_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_write_r    <= 1'b0;
            cnt_r         <= {CNT_BITS{1'b0}};
            read_valid_r  <= 1'b0;
            write_valid_r <= 1'b0;
            read_addr_r   <= {ADDR_BITS{1'b0}};
            write_addr_r  <= {ADDR_BITS{1'b0}};
            write_data_r  <= {DATA_BITS{1'b0}};
            out_r         <= {DATA_BITS{1'b0}};
            error_r       <= 1'b0;
        end else begin
            op_write_r    <= op_write_s;
            cnt_r         <= cnt_s;
            read_valid_r  <= read_valid_s;
            write_valid_r <= write_valid_s;
            read_addr_r   <= read_addr_s;
            write_addr_r  <= write_addr_s;
            write_data_r  <= write_data_s;
            out_r         <= out_s;
            error_r       <= error_s;
        end
    end

    assign mem_read_valid    = read_valid_r;
    assign mem_read_address  = read_addr_r;
    assign mem_write_valid   = write_valid_r;
    assign mem_write_address = write_addr_r;
    assign mem_write_data    = write_data_r;
    assign lsu_state         = state_r;
    assign lsu_out           = out_r;
    assign lsu_error         = error_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: scenario tasks with a queue of expected
// memory transactions, timeout shortened to 4 cycles.
import gpu_pkg::*;

module tb_lsu;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [2:0]    core_state;
    logic          rd_en, wr_en;
    logic [DB-1:0] rs, rt;
    logic          mem_read_valid, mem_read_ready;
    logic [AB-1:0] mem_read_address;
    logic [DB-1:0] mem_read_data;
    logic          mem_write_valid, mem_write_ready;
    logic [AB-1:0] mem_write_address;
    logic [DB-1:0] mem_write_data;
    logic [1:0]    lsu_state;
    logic [DB-1:0] lsu_out;
    logic          lsu_error;

    typedef struct {
        logic          wr;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .rs(rs), .rt(rt),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; core_state = CORE_FETCH; rd_en = 1'b0; wr_en = 1'b0;
        rs = 8'h00; rt = 8'h00; mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", lsu_state); end
        total++; if (mem_read_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", mem_read_valid); end
        total++; if (mem_write_valid !== 1'b0) begin bad++; $display("FAIL reset_wvalid: got %b want 0", mem_write_valid); end
        total++; if (mem_read_address !== 8'h00) begin bad++; $display("FAIL reset_raddr: got %h want 00", mem_read_address); end
        total++; if (mem_write_address !== 8'h00) begin bad++; $display("FAIL reset_waddr: got %h want 00", mem_write_address); end
        total++; if (mem_write_data !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h want 00", mem_write_data); end
        total++; if (lsu_out !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", lsu_out); end
        total++; if (lsu_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", lsu_error); end
        reset = 1'b1; enable = 1'b1;
        tick();
    endtask

    task automatic test_load();
        sb.push_back('{1'b0, 8'h2A, 8'h5C});
        core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h2A;
        tick();
        total++; if (lsu_state !== 2'd1) begin bad++; $display("FAIL load_req_state: got %0d want 1", lsu_state); end
        total++; if (mem_read_valid !== 1'b0) begin bad++; $display("FAIL load_req_rvalid: got %b want 0", mem_read_valid); end
        core_state = CORE_WAIT; rd_en = 1'b0;
        tick();
        e = sb.pop_front();
        total++; if (mem_read_valid !== 1'b1) begin bad++; $display("FAIL load_rvalid: got %b want 1", mem_read_valid); end
        total++; if (mem_read_address !== e.addr) begin bad++; $display("FAIL load_raddr: got %h want %h", mem_read_address, e.addr); end
        rs = 8'h99;
        for (int i = 0; i < 3; i++) begin
            mem_write_ready = (i == 0);
            tick();
            total++; if (lsu_state !== 2'd2) begin bad++; $display("FAIL load_wait_state[%0d]: got %0d want 2", i, lsu_state); end
            total++; if (mem_read_valid !== 1'b1) begin bad++; $display("FAIL load_hold_rvalid[%0d]: got %b want 1", i, mem_read_valid); end
            total++; if (mem_read_address !== e.addr) begin bad++; $display("FAIL load_hold_raddr[%0d]: got %h want %h", i, mem_read_address, e.addr); end
        end
        mem_write_ready = 1'b0;
        mem_read_ready = 1'b1; mem_read_data = e.data;
        tick();
        mem_read_ready = 1'b0; mem_read_data = 8'hEE;
        total++; if (lsu_state !== 2'd3) begin bad++; $display("FAIL load_done_state: got %0d want 3", lsu_state); end
        total++; if (mem_read_valid !== 1'b0) begin bad++; $display("FAIL load_done_rvalid: got %b want 0", mem_read_valid); end
        total++; if (lsu_out !== e.data) begin bad++; $display("FAIL load_out: got %h want %h", lsu_out, e.data); end
        total++; if (lsu_error !== 1'b0) begin bad++; $display("FAIL load_err: got %b want 0", lsu_error); end
        core_state = CORE_EXECUTE; mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        total++; if (lsu_state !== 2'd3) begin bad++; $display("FAIL load_hold_done: got %0d want 3", lsu_state); end
        total++; if (lsu_out !== e.data) begin bad++; $display("FAIL load_spurious_out: got %h want %h", lsu_out, e.data); end
        core_state = CORE_UPDATE;
        tick();
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL load_update_idle: got %0d want 0", lsu_state); end
        core_state = CORE_FETCH;
    endtask

    task automatic test_store();
        sb.push_back('{1'b1, 8'h10, 8'h77});
        mem_write_ready = 1'b1;
        core_state = CORE_REQUEST; wr_en = 1'b1; rs = 8'h10; rt = 8'h77;
        tick();
        total++; if (lsu_state !== 2'd1) begin bad++; $display("FAIL store_req_state: got %0d want 1", lsu_state); end
        total++; if (mem_write_valid !== 1'b0) begin bad++; $display("FAIL store_req_wvalid: got %b want 0", mem_write_valid); end
        core_state = CORE_WAIT; wr_en = 1'b0;
        tick();
        e = sb.pop_front();
        total++; if (lsu_state !== 2'd2) begin bad++; $display("FAIL store_wait_state: got %0d want 2", lsu_state); end
        total++; if (mem_write_valid !== 1'b1) begin bad++; $display("FAIL store_wvalid: got %b want 1", mem_write_valid); end
        total++; if (mem_write_address !== e.addr) begin bad++; $display("FAIL store_waddr: got %h want %h", mem_write_address, e.addr); end
        total++; if (mem_write_data !== e.data) begin bad++; $display("FAIL store_wdata: got %h want %h", mem_write_data, e.data); end
        total++; if (mem_read_valid !== 1'b0) begin bad++; $display("FAIL store_rvalid: got %b want 0", mem_read_valid); end
        rs = 8'h00; rt = 8'h00;
        tick();
        mem_write_ready = 1'b0;
        total++; if (lsu_state !== 2'd3) begin bad++; $display("FAIL store_done_state: got %0d want 3", lsu_state); end
        total++; if (mem_write_valid !== 1'b0) begin bad++; $display("FAIL store_done_wvalid: got %b want 0", mem_write_valid); end
        total++; if (mem_write_data !== e.data) begin bad++; $display("FAIL store_wdata_held: got %h want %h", mem_write_data, e.data); end
        total++; if (lsu_error !== 1'b0) begin bad++; $display("FAIL store_err: got %b want 0", lsu_error); end
        core_state = CORE_UPDATE;
        tick();
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL store_update_idle: got %0d want 0", lsu_state); end
        core_state = CORE_FETCH;
    endtask

    task automatic test_timeout();
        sb.push_back('{1'b0, 8'h33, 8'h5C});
        core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h33;
        tick();
        core_state = CORE_WAIT; rd_en = 1'b0;
        tick();
        e = sb.pop_front();
        total++; if (mem_read_address !== e.addr) begin bad++; $display("FAIL to_raddr: got %h want %h", mem_read_address, e.addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (mem_read_valid !== 1'b1) begin bad++; $display("FAIL to_rvalid_held[%0d]: got %b want 1", i, mem_read_valid); end
        end
        tick();
        total++; if (mem_read_valid !== 1'b0) begin bad++; $display("FAIL to_rvalid_drop: got %b want 0", mem_read_valid); end
        total++; if (lsu_state !== 2'd3) begin bad++; $display("FAIL to_state: got %0d want 3", lsu_state); end
        total++; if (lsu_error !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", lsu_error); end
        total++; if (lsu_out !== e.data) begin bad++; $display("FAIL to_out_held: got %h want %h", lsu_out, e.data); end
        core_state = CORE_UPDATE;
        tick();
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL to_idle: got %0d want 0", lsu_state); end
        total++; if (lsu_error !== 1'b0) begin bad++; $display("FAIL to_err_clear: got %b want 0", lsu_error); end
        core_state = CORE_FETCH;
    endtask

    task automatic test_illegal();
        core_state = CORE_REQUEST; rd_en = 1'b1; wr_en = 1'b1; rs = 8'h44; rt = 8'h55;
        tick();
        total++; if (lsu_state !== 2'd3) begin bad++; $display("FAIL illegal_state: got %0d want 3", lsu_state); end
        total++; if (lsu_error !== 1'b1) begin bad++; $display("FAIL illegal_err: got %b want 1", lsu_error); end
        core_state = CORE_WAIT; rd_en = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if ((mem_read_valid | mem_write_valid) !== 1'b0) begin bad++; $display("FAIL illegal_novalid[%0d]: got %b%b want 00", i, mem_read_valid, mem_write_valid); end
            tick();
        end
        core_state = CORE_UPDATE;
        tick();
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL illegal_idle: got %0d want 0", lsu_state); end
        total++; if (lsu_error !== 1'b0) begin bad++; $display("FAIL illegal_err_clear: got %b want 0", lsu_error); end
        core_state = CORE_FETCH;
    endtask

    task automatic test_enable_drop();
        core_state = CORE_REQUEST; wr_en = 1'b1; rs = 8'h21; rt = 8'h12;
        tick();
        core_state = CORE_WAIT; wr_en = 1'b0;
        tick();
        total++; if (mem_write_valid !== 1'b1) begin bad++; $display("FAIL en_wvalid: got %b want 1", mem_write_valid); end
        enable = 1'b0;
        tick();
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL en_state: got %0d want 0", lsu_state); end
        total++; if (mem_write_valid !== 1'b0) begin bad++; $display("FAIL en_wvalid_drop: got %b want 0", mem_write_valid); end
        total++; if (lsu_out !== 8'h5C) begin bad++; $display("FAIL en_out_held: got %h want 5c", lsu_out); end
        enable = 1'b1; core_state = CORE_FETCH; mem_write_ready = 1'b1;
        tick();
        mem_write_ready = 1'b0;
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL en_stay_idle: got %0d want 0", lsu_state); end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255))});
            core_state = CORE_REQUEST; rd_en = 1'b1; rs = sb[sb.size() - 1].addr;
            tick();
            core_state = CORE_WAIT; rd_en = 1'b0;
            n = 0;
            while (!mem_read_valid && n < 8) begin
                tick();
                n++;
            end
            total++; if (mem_read_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_wait[%0d]: got %b want 1 within 8 cycles", k, mem_read_valid); end
            e = sb.pop_front();
            total++; if (mem_read_address !== e.addr) begin bad++; $display("FAIL b2b_raddr[%0d]: got %h want %h", k, mem_read_address, e.addr); end
            repeat (k) tick();
            mem_read_ready = 1'b1; mem_read_data = e.data;
            tick();
            mem_read_ready = 1'b0; mem_read_data = 8'h00;
            total++; if (lsu_out !== e.data) begin bad++; $display("FAIL b2b_out[%0d]: got %h want %h", k, lsu_out, e.data); end
            total++; if (lsu_state !== 2'd3) begin bad++; $display("FAIL b2b_done[%0d]: got %0d want 3", k, lsu_state); end
            core_state = CORE_UPDATE;
            tick();
        end
        core_state = CORE_FETCH;
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL b2b_sb_empty: got %0d want 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        core_state = CORE_REQUEST; rd_en = 1'b1; rs = 8'h2A;
        tick();
        core_state = CORE_WAIT;
        tick();
        total++; if (mem_read_valid !== 1'b1) begin bad++; $display("FAIL ar_rvalid: got %b want 1", mem_read_valid); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (mem_read_valid !== 1'b0) begin bad++; $display("FAIL ar_rvalid_drop: got %b want 0", mem_read_valid); end
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL ar_state: got %0d want 0", lsu_state); end
        total++; if (lsu_out !== 8'h00) begin bad++; $display("FAIL ar_out: got %h want 00", lsu_out); end
        core_state = CORE_FETCH; rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();
        total++; if (lsu_state !== 2'd0) begin bad++; $display("FAIL ar_no_retry_state: got %0d want 0", lsu_state); end
        total++; if (mem_read_valid !== 1'b0) begin bad++; $display("FAIL ar_no_retry_valid: got %b want 0", mem_read_valid); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_illegal();
        test_enable_drop();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Per-thread load/store unit; one instance per thread per core.
- Turns decoded LDR/STR into a single memory transaction on one consumer port of the data-memory arbitration controller (upstream of it).
- Returns load data to the register file.
- Reports its progress so the core scheduler can stall in the WAIT stage until every thread's LSU reaches DONE.

Parameters:
- ADDR_BITS, 8, memory address width; matches the controller's ADDR_BITS.
- DATA_BITS, 8, register/data width; matches the controller's DATA_BITS.
- TIMEOUT_CYCLES, 255, maximum cycles in WAITING before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  thread active in current block; low forces idle.
- core_state  in  3  core pipeline stage (core_state_t).
- decoded_mem_read_enable  in  1  instruction is LDR.
- decoded_mem_write_enable  in  1  instruction is STR.
- rs  in  DATA_BITS  address operand; low ADDR_BITS used, zero-extended if DATA_BITS<ADDR_BITS.
- rt  in  DATA_BITS  store data.
- mem_read_valid  out  1  read request to controller.
- mem_read_address  out  ADDR_BITS  read address.
- mem_read_ready  in  1  controller read grant; data valid in the same cycle.
- mem_read_data  in  DATA_BITS  read data.
- mem_write_valid  out  1  write request to controller.
- mem_write_address  out  ADDR_BITS  write address.
- mem_write_data  out  DATA_BITS  write data.
- mem_write_ready  in  1  controller write grant.
- lsu_state  out  2  current state (lsu_state_t).
- lsu_out  out  DATA_BITS  last loaded value.
- lsu_error  out  1  timeout or illegal decode on current instruction.

Behaviour:
- Reset (async, active-low):
  - state=IDLE.
  - mem_read_valid, mem_write_valid, lsu_error = 0.
  - mem_read_address, mem_write_address, mem_write_data, lsu_out = 0.
  - Timeout counter = 0.
  - Reset mid-transaction aborts immediately; there is no retry on release.
- States: IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- enable=0 overrides everything:
  - Next edge: state=IDLE, both valids=0, lsu_error=0.
  - lsu_out holds its value.
- IDLE:
  - core_state==REQUEST and exactly one decode enable set -> REQUESTING; record op (read/write) internally; clear lsu_error.
  - Both enables set -> DONE with lsu_error=1; no memory request is issued.
  - Neither enable set -> stay IDLE.
- REQUESTING (always one cycle) -> WAITING:
  - Read: mem_read_valid<=1, mem_read_address<=rs.
  - Write: mem_write_valid<=1, mem_write_address<=rs, mem_write_data<=rt.
  - Timeout counter cleared.
  - First valid is visible 2 cycles after REQUEST is sampled.
- WAITING:
  - Valid, address and data held stable until the matching ready is sampled high.
  - Read grant: lsu_out<=mem_read_data, mem_read_valid<=0, -> DONE.
  - Write grant: mem_write_valid<=0, -> DONE.
  - No grant: counter+1 each cycle. When the counter == TIMEOUT_CYCLES-1 with no grant (TIMEOUT_CYCLES>0): valid<=0, lsu_error<=1, lsu_out unchanged, -> DONE.
  - Grant and timeout in the same cycle: the grant wins, no error.
  - Only the ready matching the recorded op is honoured.
- DONE:
  - Outputs held.
  - core_state==UPDATE -> IDLE.
  - Any other stage -> stay DONE.
- Ready inputs are ignored outside WAITING. The controller registers its grant, so one extra grant after valid drops is possible; it is tolerated and ignored.
- rs/rt are sampled only in REQUESTING; later changes have no effect.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1; it saturates and never wraps.

Decomposition:
- Shared package gpu_pkg:
  - core_state_t enum: FETCH=0, DECODE=1, REQUEST=2, WAIT=3, EXECUTE=4, UPDATE=5, DONE=6.
  - lsu_state_t enum: IDLE/REQUESTING/WAITING/DONE.
- The core scheduler also imports gpu_pkg.
- No sub-module; FSM and counter are inline.

Test Plan:
- LDR, rs=0x2A, core_state=REQUEST; memory grants read 3 cycles after valid with data 0x5C -> mem_read_address=0x2A held until grant; lsu_out=0x5C; state DONE; IDLE after UPDATE.
- STR, rs=0x10, rt=0x77; immediate grant -> mem_write_address=0x10, mem_write_data=0x77; valid high exactly until grant cycle; lsu_error=0.
- TIMEOUT_CYCLES=4, LDR, ready never asserted -> valid drops after 4 WAITING cycles; lsu_error=1; lsu_out unchanged; DONE.
- Both decode enables high at REQUEST -> no valid ever asserted; DONE with lsu_error=1; error clears on return to IDLE/new request.
- Async reset low while WAITING (read) -> valid=0, state=IDLE, lsu_out=0 immediately, not at a clock edge.
- enable dropped in WAITING; mem_write_ready pulses while in a read; spurious ready in DONE -> IDLE next edge; wrong-type and out-of-state readies cause no change.
